// File: rtl/seq_divmod_pkg.sv
// Shared types and constants for the sequential 4-bit divider.
package seq_divmod_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned STEPS = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divmod_if.sv
// Request/result handshake bundle between a requester and seq_divmod.
interface seq_divmod_if;

    logic                             start;
    logic [seq_divmod_pkg::OP_W-1:0]  A;
    logic [seq_divmod_pkg::OP_W-1:0]  B;
    logic                             ready;
    logic                             valid;
    logic                             ack;
    logic [seq_divmod_pkg::OP_W-1:0]  Q;
    logic [seq_divmod_pkg::OP_W-1:0]  R;
    logic                             div_by_zero;

    modport master (
        output start, A, B, ack,
        input  ready, valid, Q, R, div_by_zero
    );

    modport slave (
        input  start, A, B, ack,
        output ready, valid, Q, R, div_by_zero
    );

endinterface

// File: rtl/divmod_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module divmod_step
    import seq_divmod_pkg::*;
(
    input  logic [OP_W-1:0] rem_i,
    input  logic            bit_i,
    input  logic [OP_W-1:0] div_i,
    output logic [OP_W-1:0] rem_o,
    output logic            qbit_o
);

    logic [OP_W:0]   partial;
    logic [OP_W-1:0] diff;

    // Trial is non-negative exactly when partial >= divisor; the new remainder
    // is then below the divisor, so the low OP_W bits of the difference suffice.
    always_comb begin
        partial = {rem_i, bit_i};
        diff    = partial[OP_W-1:0] - div_i;
        qbit_o  = (partial >= {1'b0, div_i});
        rem_o   = qbit_o ? diff : partial[OP_W-1:0];
    end

endmodule

// File: rtl/seq_divmod.sv
// Sequential 4-bit unsigned divide/modulo, one quotient bit per CALC cycle.
module seq_divmod
    import seq_divmod_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    seq_divmod_if.slave  bus
);

    state_e            state_q;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [OP_W-1:0]   rem_q;
    logic [OP_W-2:0]   quo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OP_W-1:0]   q_q;
    logic [OP_W-1:0]   r_q;
    logic              dbz_q;
    logic              ready_q;
    logic              valid_q;

    logic [OP_W-1:0]   step_rem;
    logic              step_qbit;

    divmod_step u_step (
        .rem_i  (rem_q),
        .bit_i  (a_q[OP_W-1]),
        .div_i  (b_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Control FSM, operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        if (bus.B == '0) begin
                            q_q     <= '1;
                            r_q     <= bus.A;
                            dbz_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_q   <= {a_q[OP_W-2:0], 1'b0};
                    rem_q <= step_rem;
                    quo_q <= {quo_q[OP_W-3:0], step_qbit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        q_q     <= {quo_q, step_qbit};
                        r_q     <= step_rem;
                        dbz_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        dbz_q   <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.valid       = valid_q;
    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.div_by_zero = dbz_q;

endmodule
